// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding ld/sd of a 64-bit doubleword with a
// fixed request-to-response latency. Misaligned or out-of-range accesses
// complete with resp_err set and leave memory untouched.
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] LIMIT    = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt;
    logic          we_q;
    logic [63:0]   addr_q;
    logic [63:0]   wdata_q;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          err;
    logic          accept;
    logic          fire;
    logic          done;

    // Address decode works on the latched request so inputs may move after accept.
    // An out-of-range index is only ever used when err is clear, so it never
    // reaches the array.
    assign idx    = addr_q[3 +: AW];
    assign err    = (addr_q[2:0] != 3'd0) || (addr_q >= LIMIT);
    assign accept = (state == IDLE) && req_valid;
    assign fire   = (state == WAIT) && (cnt == 4'd0);
    assign done   = (state == RESP) && resp_ready;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: IDLE -> WAIT on accept, WAIT -> RESP when counter expires,
    // RESP -> IDLE once the initiator takes the response.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (fire)   state_nxt = RESP;
            RESP:    if (done)   state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Request capture and latency countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
        end else if (accept) begin
            cnt     <= CNT_INIT;
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response registers: loaded on the WAIT->RESP edge, cleared on hand-off
    // so they read 0 whenever resp_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end else if (fire) begin
            resp_err   <= err;
            resp_rdata <= (err || we_q) ? 64'd0 : mem[idx];
        end else if (done) begin
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end
    end

    // Storage: cleared by reset; a store commits only on its WAIT->RESP edge,
    // so a reset before that edge drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 64'd0;
        end else if (fire && we_q && !err) begin
            mem[idx] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 4) share clock and
// reset; each has its own request/response signals and a reference memory.
module tb_dmem_responder;
    logic        clk;
    logic        rst;
    logic        req_valid  [3];
    logic        req_we     [3];
    logic [63:0] req_addr   [3];
    logic [63:0] req_wdata  [3];
    logic        req_ready  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [63:0] resp_rdata [3];
    logic        resp_err   [3];

    int          lat [3];
    logic [63:0] mdl [3][32];
    int          total;
    int          bad;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH  (32),
            .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : 4)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_ready (req_ready[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 32; i++) mdl[d][i] = 64'd0;
    endtask

    // One full transaction on instance d; resp_ready is held low for 'hold'
    // edges after resp_valid rises, with a stray store pulse inside that window.
    task automatic do_req(input int d, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, input int hold, input string nm);
        bit          exp_e;
        logic [63:0] exp_d;
        int          n;
        exp_e = (addr[2:0] != 3'd0) || (addr >= 64'd256);
        exp_d = (!exp_e && !we) ? mdl[d][addr[7:3]] : 64'd0;
        @(negedge clk);
        total++;
        if (req_ready[d] !== 1'b1) begin
            bad++; $display("FAIL %s ready_idle: got %b want 1", nm, req_ready[d]);
        end
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
        @(posedge clk); #1;
        // inputs wander after accept; the latched request must be used
        req_we[d] = ~we; req_addr[d] = {$urandom(), $urandom()}; req_wdata[d] = {$urandom(), $urandom()};
        n = 0;
        while (resp_valid[d] !== 1'b1 && n < 20) begin
            total++;
            if (resp_rdata[d] !== 64'd0 || resp_err[d] !== 1'b0 || req_ready[d] !== 1'b0) begin
                bad++; $display("FAIL %s wait_outputs: rdata=%h err=%b rdy=%b want 0/0/0", nm,
                                resp_rdata[d], resp_err[d], req_ready[d]);
            end
            @(posedge clk); #1; n++;
        end
        req_valid[d] = 1'b0;
        total++;
        if (n != lat[d]) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", nm, n, lat[d]);
        end
        total++;
        if (resp_rdata[d] !== exp_d || resp_err[d] !== exp_e) begin
            bad++; $display("FAIL %s resp: rdata=%h err=%b want %h %b", nm, resp_rdata[d], resp_err[d], exp_d, exp_e);
        end
        resp_ready[d] = 1'b0;
        for (int i = 0; i < hold; i++) begin
            req_valid[d] = (i == 1);
            req_we[d] = 1'b1; req_addr[d] = 64'd0; req_wdata[d] = {$urandom(), $urandom()};
            @(posedge clk); #1;
            total++;
            if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== exp_d || resp_err[d] !== exp_e || req_ready[d] !== 1'b0) begin
                bad++; $display("FAIL %s hold%0d: v=%b rdata=%h err=%b rdy=%b want 1 %h %b 0", nm, i,
                                resp_valid[d], resp_rdata[d], resp_err[d], req_ready[d], exp_d, exp_e);
            end
        end
        req_valid[d] = 1'b0;
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
        total++;
        if (resp_valid[d] !== 1'b0 || resp_rdata[d] !== 64'd0 || resp_err[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            bad++; $display("FAIL %s handoff: v=%b rdata=%h err=%b rdy=%b want 0 0 0 1", nm,
                            resp_valid[d], resp_rdata[d], resp_err[d], req_ready[d]);
        end
        if (we && !exp_e) mdl[d][addr[7:3]] = wdata;
    endtask

    task automatic check_cleared(input string nm);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 64'd0 || resp_err[d] !== 1'b0) begin
                bad++; $display("FAIL %s dut%0d: rdy=%b v=%b rdata=%h err=%b want 1 0 0 0", nm, d,
                                req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1 check_cleared("reset_pulse");
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        #3 check_cleared("reset_state");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        do_req(0, 1'b1, 64'h18, 64'h5, 0, "sd_0x18");
        do_req(0, 1'b0, 64'h18, 64'h0, 0, "ld_0x18");
    endtask

    task automatic test_misaligned();
        do_req(0, 1'b0, 64'h14, 64'h0, 0, "ld_misaligned");
        do_req(0, 1'b1, 64'h1F, 64'hDEAD, 1, "sd_misaligned");
        do_req(0, 1'b0, 64'h10, 64'h0, 0, "ld_0x10");
        do_req(0, 1'b0, 64'h18, 64'h0, 0, "ld_0x18_again");
    endtask

    task automatic test_out_of_range();
        pulse_reset();
        do_req(0, 1'b1, 64'hFFFFFFFF_FFFFFFF4, 64'hAA, 0, "sd_negative");
        do_req(0, 1'b1, 64'h100, 64'hBB, 0, "sd_limit");
        for (int i = 0; i < 32; i++) do_req(0, 1'b0, 64'(i * 8), 64'h0, 0, "ld_sweep");
    endtask

    task automatic test_backpressure();
        do_req(0, 1'b1, 64'h0, 64'hCAFE_F00D_1234_5678, 0, "sd_0x00");
        do_req(0, 1'b0, 64'h0, 64'h0, 5, "ld_backpressure");
        do_req(0, 1'b0, 64'h0, 64'h0, 0, "ld_0x00_after_bp");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 64'h08; req_wdata[0] = 64'h1234;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1 check_cleared("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        do_req(0, 1'b0, 64'h08, 64'h0, 0, "ld_after_abort");
    endtask

    task automatic test_latency();
        for (int d = 1; d < 3; d++) begin
            do_req(d, 1'b1, 64'h28, 64'h77 + 64'(d), 0, "lat_sd");
            do_req(d, 1'b0, 64'h28, 64'h0, 2, "lat_ld");
            do_req(d, 1'b0, 64'h2C, 64'h0, 0, "lat_err");
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 80; k++) begin
            int          d;
            logic [63:0] a;
            d = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0, 1:    a = {56'd0, 5'($urandom_range(0, 31)), 3'd0};
                2:       a = {56'd0, 5'($urandom_range(0, 31)), 3'($urandom_range(1, 7))};
                default: a = {$urandom(), $urandom()} | 64'h1000;
            endcase
            do_req(d, 1'($urandom_range(0, 1)), a, {$urandom(), $urandom()}, $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        total = 0; bad = 0;
        lat[0] = 2; lat[1] = 1; lat[2] = 4;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 64'd0;
            req_wdata[d] = 64'd0; resp_ready[d] = 1'b0;
        end
        clear_model();
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_latency();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of 64-bit doublewords stored.
REQ-002 SHALL have parameter LATENCY, default 2, range 1-15, meaning clock edges from request accept to response valid.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a load/store request.
REQ-006 SHALL have port req_we  input  1  1 = store (sd), 0 = load (ld).
REQ-007 SHALL have port req_addr  input  64  byte address computed by the datapath (base + sign-extended offset).
REQ-008 SHALL have port req_wdata  input  64  store data.
REQ-009 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-010 SHALL have port resp_valid  output  1  response fields valid.
REQ-011 SHALL have port resp_ready  input  1  initiator consumes the response.
REQ-012 SHALL have port resp_rdata  output  64  load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  access was misaligned or out of range.

Function
REQ-014 SHALL implement FSM with states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request on a rising edge where state = IDLE and req_valid = 1, latching req_we, req_addr and req_wdata, loading a latency counter with LATENCY-1 and entering WAIT.
REQ-016 SHALL, in WAIT, decrement the counter each edge and transition to RESP on the edge where the counter is 0, so resp_valid rises exactly LATENCY edges after the accept edge.
REQ-017 SHALL ignore req_valid and the request inputs while in WAIT or RESP; request inputs may change freely after the accept edge.
REQ-018 SHALL index the memory with latched addr[3+log2(DEPTH)-1:3] (addr[7:3] at default).
REQ-019 SHALL flag an error when latched addr[2:0] != 0 or addr >= DEPTH*8 (unsigned; a negative effective address is therefore out of range).
REQ-020 SHALL, on the WAIT->RESP edge, write the latched wdata to the indexed doubleword for a valid store, or register the indexed doubleword into resp_rdata for a valid load.
REQ-021 SHALL, on error, perform no memory write, drive resp_rdata = 0 and resp_err = 1.
REQ-022 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until an edge with resp_ready = 1, then enter IDLE with resp_valid = 0, resp_err = 0 and resp_rdata = 0.
REQ-023 SHALL allow a new request only from IDLE; back-to-back throughput is therefore one request per LATENCY+2 edges minimum.
REQ-024 SHALL make a store visible to any later load of the same address (no stale data).
REQ-025 SHALL drive resp_err = 0 and resp_rdata = 0 whenever resp_valid = 0.

Reset
REQ-026 SHALL, while rst = 1, immediately force state IDLE, counter 0, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0 and clear all memory words to 0.
REQ-027 SHALL abort any in-flight request on rst, including dropping a pending store that has not reached the WAIT->RESP edge.
REQ-028 SHALL accept the first request on the first rising edge after rst deasserts.

Verification
REQ-029 Store then load: sd addr 0x18, wdata 0x00000000_00000005 -> resp_valid 2 edges after accept, rdata 0, err 0; then ld addr 0x18 -> rdata 0x00000000_00000005.
REQ-030 Misaligned: ld addr 0x14 -> resp_err 1, rdata 0; a following ld 0x10 returns 0 (no corruption).
REQ-031 Out of range: sd addr 0xFFFFFFFF_FFFFFFF4 wdata 0xAA -> resp_err 1; ld of every index 0..31 still returns 0.
REQ-032 Backpressure: ld 0x00 with resp_ready held 0 for 5 cycles -> resp_valid and rdata stable for all 5, req_ready 0 and a req_valid pulse in that window is ignored; IDLE on first resp_ready = 1 edge.
REQ-033 Reset mid-operation: sd addr 0x08 wdata 0x1234, assert rst one edge after accept -> outputs cleared immediately, later ld 0x08 returns 0.
REQ-034 Latency sweep: LATENCY = 1 and 4 -> resp_valid rises exactly 1 and 4 edges after accept respectively.
